// File: rtl/vscale_htif_tohost_poller_pkg.sv
// Shared definitions for the HTIF tohost poller: CSR map, tohost encodings and FSM states.
// Pure constants and types; no logic, no latency, no flow control.
package vscale_htif_tohost_poller_pkg;

   localparam int HTIF_PCR_WIDTH = 64;
   localparam int CSR_ADDR_WIDTH = 12;

   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST   = 12'h780;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_FROM_HOST = 12'h781;

   localparam logic        PCR_REQ_READ  = 1'b0;
   localparam logic        PCR_REQ_WRITE = 1'b1;

   // tohost protocol: 0 = still running, 1 = pass, anything else = fail with code in the upper bits
   localparam logic [HTIF_PCR_WIDTH-1:0] TOHOST_IDLE = 64'd0;
   localparam logic [HTIF_PCR_WIDTH-1:0] TOHOST_PASS = 64'd1;
   localparam int                        TOHOST_FAIL_SHIFT = 1;

   typedef enum logic [2:0] {
      ST_WAIT     = 3'd0,
      ST_RD_REQ   = 3'd1,
      ST_RD_RESP  = 3'd2,
      ST_CLR_REQ  = 3'd3,
      ST_CLR_RESP = 3'd4,
      ST_DONE     = 3'd5
   } poll_state_t;

endpackage

// File: rtl/vscale_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
// One cycle from enable to new count; holds at all-ones instead of wrapping.
module vscale_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             i_clr_n,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!i_clr_n) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/vscale_htif_tohost_poller.sv
// Polls CSR tohost over the HTIF PCR port, clears it on a verdict and reports sticky done/pass/fail/timeout.
// Verdict to done in >=3 cycles; one transaction outstanding, req held stable until req_ready.
module vscale_htif_tohost_poller
   import vscale_htif_tohost_poller_pkg::*;
#(
   parameter int                    PCR_WIDTH     = HTIF_PCR_WIDTH,
   parameter int                    ADDR_WIDTH    = CSR_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR   = ADDR_WIDTH'(CSR_ADDR_TO_HOST),
   parameter int                    POLL_INTERVAL = 4,
   parameter int                    CNT_WIDTH     = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CNT_WIDTH-1:0]  max_cycles,
   output logic                  htif_pcr_req_valid,
   input  logic                  htif_pcr_req_ready,
   output logic                  htif_pcr_req_rw,
   output logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
   output logic [PCR_WIDTH-1:0]  htif_pcr_req_data,
   input  logic                  htif_pcr_resp_valid,
   output logic                  htif_pcr_resp_ready,
   input  logic [PCR_WIDTH-1:0]  htif_pcr_resp_data,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic [PCR_WIDTH-2:0]  fail_code,
   output logic                  timeout,
   output logic [CNT_WIDTH-1:0]  cycle_count
);

   localparam int INT_W = $clog2(POLL_INTERVAL + 1);

   poll_state_t          r_state;
   logic                 r_req_valid;
   logic                 r_req_rw;
   logic                 r_resp_ready;
   logic                 r_done;
   logic                 r_pass;
   logic                 r_fail;
   logic                 r_timeout;
   logic [PCR_WIDTH-2:0] r_fail_code;

   logic [INT_W-1:0]     w_interval;
   logic [CNT_WIDTH-1:0] w_cycles;
   logic                 w_req_fire;
   logic                 w_resp_fire;
   logic                 w_rd_idle;
   logic                 w_rd_pass;
   logic                 w_interval_end;
   logic                 w_interval_clr_n;
   logic                 w_timeout_hit;
   logic                 w_timeout_now;
   logic                 w_done_set;
   logic                 w_cycle_en;

   assign w_req_fire       = r_req_valid && htif_pcr_req_ready;
   assign w_resp_fire      = r_resp_ready && htif_pcr_resp_valid;
   assign w_rd_idle        = (htif_pcr_resp_data == PCR_WIDTH'(TOHOST_IDLE));
   assign w_rd_pass        = (htif_pcr_resp_data == PCR_WIDTH'(TOHOST_PASS));
   assign w_interval_end   = (w_interval == INT_W'(POLL_INTERVAL - 1));
   assign w_interval_clr_n = reset && (r_state == ST_WAIT);

   // A decoded verdict always wins: once pass/fail is latched the limit no longer applies.
   assign w_timeout_hit = (max_cycles != '0) && (w_cycles >= max_cycles) && !r_pass && !r_fail;

   always_comb begin
      w_timeout_now = 1'b0;
      case (r_state)
         ST_WAIT:    w_timeout_now = w_timeout_hit;
         ST_RD_REQ:  w_timeout_now = w_timeout_hit && !w_req_fire;
         ST_RD_RESP: w_timeout_now = w_timeout_hit && w_resp_fire && w_rd_idle;
         default:    w_timeout_now = 1'b0;
      endcase
   end

   // Counter freezes on the same edge that raises done, so it reports the cycle of the verdict.
   assign w_done_set = w_timeout_now || ((r_state == ST_CLR_RESP) && w_resp_fire);
   assign w_cycle_en = !r_done && !w_done_set;

   vscale_sat_counter #(.WIDTH(INT_W)) u_interval_cnt (
      .clk     (clk),
      .i_clr_n (w_interval_clr_n),
      .i_en    (1'b1),
      .o_count (w_interval)
   );

   vscale_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clk     (clk),
      .i_clr_n (reset),
      .i_en    (w_cycle_en),
      .o_count (w_cycles)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_WAIT;
         r_req_valid  <= 1'b0;
         r_req_rw     <= PCR_REQ_READ;
         r_resp_ready <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail       <= 1'b0;
         r_timeout    <= 1'b0;
         r_fail_code  <= '0;
      end else if (w_timeout_now) begin
         r_state      <= ST_DONE;
         r_req_valid  <= 1'b0;
         r_resp_ready <= 1'b1;
         r_done       <= 1'b1;
         r_timeout    <= 1'b1;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (w_interval_end) begin
                  r_state     <= ST_RD_REQ;
                  r_req_valid <= 1'b1;
                  r_req_rw    <= PCR_REQ_READ;
               end
            end
            ST_RD_REQ: begin
               if (w_req_fire) begin
                  r_state      <= ST_RD_RESP;
                  r_req_valid  <= 1'b0;
                  r_resp_ready <= 1'b1;
               end
            end
            ST_RD_RESP: begin
               if (w_resp_fire) begin
                  r_resp_ready <= 1'b0;
                  if (w_rd_idle) begin
                     r_state <= ST_WAIT;
                  end else begin
                     r_state     <= ST_CLR_REQ;
                     r_req_valid <= 1'b1;
                     r_req_rw    <= PCR_REQ_WRITE;
                     if (w_rd_pass) begin
                        r_pass <= 1'b1;
                     end else begin
                        r_fail      <= 1'b1;
                        r_fail_code <= htif_pcr_resp_data[PCR_WIDTH-1:TOHOST_FAIL_SHIFT];
                     end
                  end
               end
            end
            ST_CLR_REQ: begin
               if (w_req_fire) begin
                  r_state      <= ST_CLR_RESP;
                  r_req_valid  <= 1'b0;
                  r_resp_ready <= 1'b1;
               end
            end
            ST_CLR_RESP: begin
               if (w_resp_fire) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               // Stay ready so late or stray responses drain instead of stalling the target.
               r_resp_ready <= 1'b1;
            end
            default: begin
               r_state      <= ST_WAIT;
               r_req_valid  <= 1'b0;
               r_resp_ready <= 1'b0;
            end
         endcase
      end
   end

   assign htif_pcr_req_valid  = r_req_valid;
   assign htif_pcr_req_rw     = r_req_rw;
   assign htif_pcr_req_addr   = TOHOST_ADDR;
   assign htif_pcr_req_data   = '0;
   assign htif_pcr_resp_ready = r_resp_ready;
   assign done                = r_done;
   assign pass                = r_pass;
   assign fail                = r_fail;
   assign fail_code           = r_fail_code;
   assign timeout             = r_timeout;
   assign cycle_count         = w_cycles;

endmodule

// File: tb/tb_vscale_htif_tohost_poller.sv
// Directed bench for the tohost poller: table of full-run scenarios plus handshake and reset sequences.
module tb_vscale_htif_tohost_poller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] max_cycles = 64'd0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic        req_rw;
   logic [11:0] req_addr;
   logic [63:0] req_data;
   logic        resp_valid = 1'b0;
   logic        resp_ready;
   logic [63:0] resp_data = 64'd0;
   logic        done, pass, fail, timeout;
   logic [62:0] fail_code;
   logic [63:0] cycle_count;

   always #5 clk = ~clk;

   vscale_htif_tohost_poller dut (
      .clk                 (clk),
      .reset               (reset),
      .max_cycles          (max_cycles),
      .htif_pcr_req_valid  (req_valid),
      .htif_pcr_req_ready  (req_ready),
      .htif_pcr_req_rw     (req_rw),
      .htif_pcr_req_addr   (req_addr),
      .htif_pcr_req_data   (req_data),
      .htif_pcr_resp_valid (resp_valid),
      .htif_pcr_resp_ready (resp_ready),
      .htif_pcr_resp_data  (resp_data),
      .done                (done),
      .pass                (pass),
      .fail                (fail),
      .fail_code           (fail_code),
      .timeout             (timeout),
      .cycle_count         (cycle_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Responder model of the PCR target: one transaction at a time, response presented the cycle after accept.
   bit          ready_en = 1'b1;
   bit          block_wr = 1'b0;
   logic [63:0] rd_q[$];
   int          rd_cnt = 0, wr_cnt = 0, wr_bad = 0;
   bit          pend = 1'b0;
   logic [63:0] pdata = 64'd0;
   bit          req_fire_q = 1'b0, resp_fire_q = 1'b0;
   logic        fire_rw = 1'b0;
   logic [11:0] fire_addr = 12'd0;
   logic [63:0] fire_data = 64'd0;

   always @(negedge clk) begin
      if (!reset) begin
         pend = 1'b0; req_fire_q = 1'b0; resp_fire_q = 1'b0;
         rd_cnt = 0; wr_cnt = 0; wr_bad = 0;
         resp_valid = 1'b0; resp_data = 64'd0; req_ready = 1'b0;
      end else begin
         if (resp_fire_q) pend = 1'b0;
         if (req_fire_q) begin
            pend = 1'b1;
            if (fire_rw) begin
               wr_cnt++;
               pdata = 64'd0;
               if (fire_addr != 12'h780 || fire_data != 64'd0) wr_bad++;
            end else begin
               rd_cnt++;
               pdata = (rd_q.size() > 0) ? rd_q.pop_front() : 64'd0;
            end
         end
         resp_valid  = pend;
         resp_data   = pend ? pdata : 64'd0;
         req_ready   = ready_en && !(block_wr && req_rw);
         req_fire_q  = req_valid && req_ready;
         fire_rw     = req_rw;
         fire_addr   = req_addr;
         fire_data   = req_data;
         resp_fire_q = resp_valid && resp_ready;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 2000 && done !== 1'b1; i++) step(1);
      check64({name, "_done"}, {63'd0, done}, 64'd1);
   endtask

   typedef struct {
      int          n_zero;
      logic [63:0] final_val;
      logic [63:0] max_cyc;
      logic        e_pass;
      logic        e_fail;
      logic        e_to;
      logic [62:0] e_code;
      logic [63:0] e_count;
      int          e_reads;
      int          e_writes;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int          unstable;
      logic [63:0] cnt_snap;
      int          rd_snap, wr_snap;

      // poll period is 6 cycles: read k accepted at edge 5+6k, answered at 6+6k; verdict -> done at count 7+6n
      vecs[0]  = '{10, 64'd1, 64'd0, 1, 0, 0, 63'd0, 64'd67, 11, 1};
      vecs[1]  = '{0, 64'd7, 64'd0, 0, 1, 0, 63'd3, 64'd7, 1, 1};
      vecs[2]  = '{1, 64'h8000_0000_0000_0000, 64'd0, 0, 1, 0, 63'h4000_0000_0000_0000, 64'd13, 2, 1};
      vecs[3]  = '{0, 64'd2, 64'd0, 0, 1, 0, 63'd1, 64'd7, 1, 1};
      vecs[4]  = '{0, 64'd0, 64'd50, 0, 0, 1, 63'd0, 64'd50, 8, 0};
      vecs[5]  = '{2, 64'd1, 64'd17, 1, 0, 0, 63'd0, 64'd19, 3, 1};
      vecs[6]  = '{0, 64'd0, 64'd11, 0, 0, 1, 63'd0, 64'd11, 2, 0};
      vecs[7]  = '{0, 64'd0, 64'd10, 0, 0, 1, 63'd0, 64'd11, 2, 0};
      vecs[8]  = '{0, 64'd0, 64'd9, 0, 0, 1, 63'd0, 64'd9, 1, 0};
      vecs[9]  = '{0, 64'd0, 64'd1, 0, 0, 1, 63'd0, 64'd1, 0, 0};
      vecs[10] = '{1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 63'd0, 64'd13, 2, 1};

      reset = 1'b0;
      step(2);
      check64("reset_flags", {58'd0, done, pass, fail, timeout, req_valid, resp_ready}, 64'd0);
      check64("reset_fail_code", {1'b0, fail_code}, 64'd0);
      check64("reset_cycle_count", cycle_count, 64'd0);

      for (int r = 0; r < 11; r++) begin
         reset = 1'b0; ready_en = 1'b1; block_wr = 1'b0; rd_q.delete();
         step(2);
         for (int z = 0; z < vecs[r].n_zero; z++) rd_q.push_back(64'd0);
         rd_q.push_back(vecs[r].final_val);
         max_cycles = vecs[r].max_cyc;
         reset = 1'b1;
         wait_done($sformatf("row%0d", r));
         check64($sformatf("row%0d_pass", r), {63'd0, pass}, {63'd0, vecs[r].e_pass});
         check64($sformatf("row%0d_fail", r), {63'd0, fail}, {63'd0, vecs[r].e_fail});
         check64($sformatf("row%0d_timeout", r), {63'd0, timeout}, {63'd0, vecs[r].e_to});
         check64($sformatf("row%0d_fail_code", r), {1'b0, fail_code}, {1'b0, vecs[r].e_code});
         check64($sformatf("row%0d_cycle_count", r), cycle_count, vecs[r].e_count);
         check64($sformatf("row%0d_reads", r), 64'(rd_cnt), 64'(vecs[r].e_reads));
         check64($sformatf("row%0d_writes", r), 64'(wr_cnt), 64'(vecs[r].e_writes));
         check64($sformatf("row%0d_write_fields", r), 64'(wr_bad), 64'd0);
         cnt_snap = cycle_count; rd_snap = rd_cnt; wr_snap = wr_cnt;
         step(8);
         check64($sformatf("row%0d_quiet_after_done", r),
                 {62'd0, req_valid, resp_ready}, 64'd1);
         check64($sformatf("row%0d_no_more_txn", r), 64'(rd_cnt + wr_cnt), 64'(rd_snap + wr_snap));
         check64($sformatf("row%0d_count_frozen", r), cycle_count, cnt_snap);
      end

      // req_ready held low: request must stay put and be accepted exactly once
      reset = 1'b0; ready_en = 1'b0; block_wr = 1'b0; rd_q.delete(); max_cycles = 64'd0;
      step(2);
      reset = 1'b1;
      for (int i = 0; i < 20 && req_valid !== 1'b1; i++) step(1);
      check64("stall_req_seen", {63'd0, req_valid}, 64'd1);
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (!(req_valid === 1'b1 && req_addr === 12'h780 && req_rw === 1'b0 && req_data === 64'd0))
            unstable++;
      end
      check64("stall_req_stable", 64'(unstable), 64'd0);
      check64("stall_no_accept", 64'(rd_cnt), 64'd0);
      ready_en = 1'b1;
      step(4);
      check64("stall_one_read", 64'(rd_cnt), 64'd1);
      check64("stall_back_to_wait", {63'd0, req_valid}, 64'd0);

      // reset while the clear write is stalled in CLR_REQ
      reset = 1'b0; ready_en = 1'b1; block_wr = 1'b1; rd_q.delete(); rd_q.push_back(64'd1);
      step(2);
      reset = 1'b1;
      for (int i = 0; i < 40 && !(req_valid === 1'b1 && req_rw === 1'b1); i++) step(1);
      check64("clr_req_seen", {62'd0, req_valid, req_rw}, 64'd3);
      step(2);
      check64("clr_req_held", {62'd0, req_valid, pass}, 64'd3);
      reset = 1'b0;
      step(1);
      check64("midreset_flags", {58'd0, done, pass, fail, timeout, req_valid, resp_ready}, 64'd0);
      check64("midreset_count", cycle_count, 64'd0);
      block_wr = 1'b0; rd_q.delete(); rd_q.push_back(64'd1);
      reset = 1'b1;
      step(3);
      check64("restart_wait_idle", {62'd0, req_valid, resp_ready}, 64'd0);
      step(1);
      check64("restart_first_read", {62'd0, req_valid, req_rw}, 64'd2);
      wait_done("restart");
      check64("restart_pass", {61'd0, pass, fail, timeout}, 64'd4);
      check64("restart_writes", 64'(wr_cnt), 64'd1);
      check64("restart_cycle_count", cycle_count, 64'd7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/vscale_htif_tohost_poller.md
Name: vscale_htif_tohost_poller

Overview:
Synthesizable host-side HTIF poller that sits directly upstream of vscale_sim_top's HTIF PCR port and consumes its PCR responses.
- Periodically reads CSR tohost over the PCR req/resp handshake.
- Decodes pass/fail and clears tohost with a write of 0.
- Enforces a cycle timeout.
- Exposes sticky done/pass/fail/timeout status, so benches and FPGA wrappers no longer need behavioural polling.

Parameters:
PCR_WIDTH, 64, HTIF PCR data width
ADDR_WIDTH, 12, CSR address width
TOHOST_ADDR, 12'h780, CSR address polled and cleared
POLL_INTERVAL, 4, idle cycles between reads (>=1)
CNT_WIDTH, 64, width of cycle counter and max_cycles

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
max_cycles  input  CNT_WIDTH  timeout limit; 0 disables timeout
htif_pcr_req_valid  output  1  request valid
htif_pcr_req_ready  input  1  DUT accepts request
htif_pcr_req_rw  output  1  1=write, 0=read
htif_pcr_req_addr  output  ADDR_WIDTH  always TOHOST_ADDR
htif_pcr_req_data  output  PCR_WIDTH  write data, always 0
htif_pcr_resp_valid  input  1  response valid
htif_pcr_resp_ready  output  1  poller accepts response
htif_pcr_resp_data  input  PCR_WIDTH  response data
done  output  1  sticky: test finished (pass, fail or timeout)
pass  output  1  sticky: tohost==1 seen
fail  output  1  sticky: tohost nonzero and !=1
fail_code  output  PCR_WIDTH-1  tohost>>1 captured on fail
timeout  output  1  sticky: limit reached
cycle_count  output  CNT_WIDTH  cycles since reset release, frozen at done

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to WAIT, interval counter to 0.
  - All status outputs, fail_code and cycle_count go to 0.
  - req_valid=0, resp_ready=0.
  - Reset mid-transaction abandons it; no handshake state is retained.
- States:
  - WAIT: counts POLL_INTERVAL cycles, then moves to RD_REQ.
  - RD_REQ: req_valid=1, rw=0. On req_valid&&req_ready, moves to RD_RESP.
  - RD_RESP: resp_ready=1. On resp_valid the data is decoded:
    - data==0: go to WAIT.
    - data==1: set pass, go to CLR_REQ.
    - otherwise: set fail, latch fail_code=data[PCR_WIDTH-1:1], go to CLR_REQ.
  - CLR_REQ: req_valid=1, rw=1, data=0. On handshake, moves to CLR_RESP.
  - CLR_RESP: resp_ready=1. On resp_valid, sets done and moves to DONE.
  - DONE: terminal. req_valid=0, resp_ready=1 so stray responses are drained. Only reset exits.
- Handshake rules:
  - req_valid, once asserted, stays high with stable rw/addr/data until req_ready is sampled high.
  - A request and a response are never both in flight (one outstanding transaction).
  - A response arriving in a state other than RD_RESP, CLR_RESP or DONE is ignored; resp_ready is 0 in those states.
- Cycle counter:
  - Increments every cycle while reset==1 and done==0.
  - Saturates at all-ones.
- Timeout:
  - Condition: max_cycles!=0 and cycle_count>=max_cycles.
  - If a request is not yet accepted, or the state is WAIT: set timeout and done, go to DONE immediately, deassert req_valid.
  - If a response is outstanding (RD_RESP or CLR_RESP): finish that response first, then set timeout and done.
- Same-cycle timeout and pass/fail decode: pass/fail takes priority. timeout stays 0 and the clear sequence proceeds.
- pass, fail and timeout are mutually exclusive. Exactly one is set when done rises.
- Latency from a nonzero response to done: response cycle, plus CLR_REQ handshake, plus clear response; minimum 3 cycles.

Decomposition:
- Shared package/header (alongside the CSR address map and control constants) holds:
  - state encodings (3-bit),
  - CSR_ADDR_TO_HOST,
  - HTIF_PCR_WIDTH,
  - the tohost decode values: PASS=1, IDLE=0, fail code = data>>1.
- One sub-module, vscale_sat_counter: a parameterized saturating up-counter with enable and synchronous active-low clear. It is used for both the interval counter and the cycle counter.

Test Plan:
- Tohost reads 0 for 10 polls, then 1 -> pass=1 and done=1; one write of data=0 to 0x780 issued; fail=0, timeout=0.
- Tohost returns 0x0000_0000_0000_0007 -> fail=1, fail_code=3, clear write issued, done=1.
- req_ready held low 20 cycles during RD_REQ -> req_valid, addr=0x780 and rw=0 stay stable throughout; exactly one read is accepted.
- max_cycles=50 with tohost always 0 -> timeout=1 and done=1; cycle_count=50; no further requests after done.
- Timeout reached in the same cycle as a resp_data=1 response -> pass=1, timeout=0.
- reset pulled low while in CLR_REQ -> all outputs return to 0 next cycle; polling restarts from WAIT after release.
